// File: rtl/cache_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : cache_init_seq
// Description : Cache maintenance sweep sequencer. After reset it runs an
//               invalidate sweep over every (set, way) pair. It then waits for
//               write-back flush requests and runs a flush sweep for each one,
//               pulsing flush_ack_o when that sweep finishes.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_init_seq #(
   parameter  int IDX_LEN = 6,
   parameter  int N_WAYS  = 4,
   localparam int WAY_LEN = (N_WAYS > 1) ? $clog2(N_WAYS) : 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_req_i,
   output logic               flush_ack_o,
   output logic               init_done_o,
   output logic               busy_o,
   output logic               req_valid_o,
   input  logic               req_ready_i,
   output logic [IDX_LEN-1:0] req_idx_o,
   output logic [WAY_LEN-1:0] req_way_o,
   output logic               req_wb_o
);

   localparam logic [WAY_LEN-1:0] WAY_LAST = WAY_LEN'(N_WAYS - 1);

   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_IDLE  = 2'd1,
      S_FLUSH = 2'd2,
      S_ACK   = 2'd3
   } state_e;

   state_e             state_q;
   logic [IDX_LEN-1:0] idx_q, idx_d;
   logic [WAY_LEN-1:0] way_q, way_d;
   logic               init_done_q;

   logic sweeping;
   logic hs;
   logic way_last;
   logic idx_last;
   logic term;

   // A request is outstanding only in the two sweep states.
   assign sweeping = (state_q == S_INIT) || (state_q == S_FLUSH);
   assign hs       = sweeping & req_ready_i;
   assign way_last = (way_q == WAY_LAST);
   assign idx_last = &idx_q;
   assign term     = hs & way_last & idx_last;

   // Next counter position: ways first, then sets; holds without a handshake.
   always_comb begin
      idx_d = idx_q;
      way_d = way_q;
      if (hs) begin
         if (way_last) begin
            way_d = '0;
            idx_d = idx_q + 1'b1;
         end else begin
            way_d = way_q + 1'b1;
         end
      end
   end

   // Sweep FSM: counters, state and the sticky init-done flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_INIT;
         idx_q       <= '0;
         way_q       <= '0;
         init_done_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_INIT: begin
               if (term) begin
                  state_q     <= S_IDLE;
                  init_done_q <= 1'b1;
                  idx_q       <= '0;
                  way_q       <= '0;
               end else begin
                  idx_q <= idx_d;
                  way_q <= way_d;
               end
            end
            S_IDLE: begin
               idx_q <= '0;
               way_q <= '0;
               if (flush_req_i) begin
                  state_q <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               if (term) begin
                  state_q <= S_ACK;
                  idx_q   <= '0;
                  way_q   <= '0;
               end else begin
                  idx_q <= idx_d;
                  way_q <= way_d;
               end
            end
            S_ACK: begin
               state_q <= S_IDLE;
               idx_q   <= '0;
               way_q   <= '0;
            end
            default: begin
               state_q <= S_INIT;
               idx_q   <= '0;
               way_q   <= '0;
            end
         endcase
      end
   end

   // Outputs decode directly from registered state, so they are glitch-free
   // and take their reset values while rst_ni is low.
   assign req_valid_o = sweeping;
   assign busy_o      = sweeping;
   assign req_wb_o    = (state_q == S_FLUSH);
   assign flush_ack_o = (state_q == S_ACK);
   assign init_done_o = init_done_q;
   assign req_idx_o   = idx_q;
   assign req_way_o   = way_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_init_seq
// Description : Scoreboard bench for cache_init_seq. Two instances run side by
//               side (N_WAYS=2 and N_WAYS=3, IDX_LEN=2). Starting a sweep
//               queues the full expected (idx, way, wb) list computed from the
//               linear handshake number; a monitor pops and compares on every
//               handshake and checks status outputs each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_init_seq;

   localparam int IDX_LEN = 2;
   localparam int NSETS   = 1 << IDX_LEN;

   typedef struct {
      int idx;
      int way;
      int wb;
      bit last;
   } hs_t;

   logic       clk;
   logic       rst_n;
   logic       ready;
   logic [1:0] flush_req;
   logic [1:0] ack, done, busy, valid, wb;
   logic [IDX_LEN-1:0] idx0, idx1;
   logic       way0;
   logic [1:0] way1;

   int  checks = 0;
   int  errors = 0;
   int  ready_mode = 0;   // 0: always 1, 1: toggle, 2: random

   hs_t sq [2][$];
   int  nways     [2] = '{2, 3};
   int  init_cnt  [2];
   bit  pend_ack  [2];
   bit  prev_stall[2];
   int  prev_idx  [2];
   int  prev_way  [2];
   int  prev_wb   [2];
   hs_t e;

   cache_init_seq #(.IDX_LEN(IDX_LEN), .N_WAYS(2)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .flush_req_i(flush_req[0]),
      .flush_ack_o(ack[0]), .init_done_o(done[0]), .busy_o(busy[0]),
      .req_valid_o(valid[0]), .req_ready_i(ready), .req_idx_o(idx0),
      .req_way_o(way0), .req_wb_o(wb[0])
   );

   cache_init_seq #(.IDX_LEN(IDX_LEN), .N_WAYS(3)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .flush_req_i(flush_req[1]),
      .flush_ack_o(ack[1]), .init_done_o(done[1]), .busy_o(busy[1]),
      .req_valid_o(valid[1]), .req_ready_i(ready), .req_idx_o(idx1),
      .req_way_o(way1), .req_wb_o(wb[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: actual=%0d required=%0d at %0t", name, k, act, exp, $time);
      end
   endtask

   // Queue every handshake of one sweep, numbered linearly n = idx*N + way.
   task automatic push_sweep(input int k, input int wbv);
      hs_t x;
      int  total;
      total = nways[k] * NSETS;
      for (int n = 0; n < total; n++) begin
         x.idx  = n / nways[k];
         x.way  = n % nways[k];
         x.wb   = wbv;
         x.last = (n == total - 1);
         sq[k].push_back(x);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       ready = 1'b1;
         1:       ready = ~ready;
         default: ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic wait_init();
      for (int c = 0; c < 400 && !(done[0] && done[1]); c++) step();
      chk("init_timeout", 0, done[0], 1);
      chk("init_timeout", 1, done[1], 1);
   endtask

   task automatic wait_acks();
      bit got [2];
      got = '{0, 0};
      for (int c = 0; c < 600 && !(got[0] && got[1]); c++) begin
         step();
         for (int k = 0; k < 2; k++) begin
            if (ack[k]) begin
               got[k]       = 1;
               flush_req[k] = 1'b0;
            end
         end
      end
      chk("ack_timeout", 0, got[0], 1);
      chk("ack_timeout", 1, got[1], 1);
      flush_req = 2'b00;
   endtask

   // Monitor / scoreboard.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int ci, cw, total;
         ci    = (k == 0) ? int'(idx0) : int'(idx1);
         cw    = (k == 0) ? int'(way0) : int'(way1);
         total = nways[k] * NSETS;
         if (!rst_n) begin
            chk("rst_valid", k, valid[k], 1);
            chk("rst_wb",    k, wb[k],    0);
            chk("rst_busy",  k, busy[k],  1);
            chk("rst_idx",   k, ci,       0);
            chk("rst_way",   k, cw,       0);
            chk("rst_done",  k, done[k],  0);
            chk("rst_ack",   k, ack[k],   0);
            sq[k].delete();
            init_cnt[k]   = 0;
            pend_ack[k]   = 0;
            prev_stall[k] = 0;
         end else begin
            chk("init_done", k, done[k], (init_cnt[k] == total) ? 1 : 0);
            chk("flush_ack", k, ack[k], pend_ack[k]);
            pend_ack[k] = 0;
            chk("busy", k, busy[k], valid[k]);
            chk("way_range", k, (cw < nways[k]) ? 1 : 0, 1);
            if (prev_stall[k]) begin
               chk("stall_idx", k, ci,    prev_idx[k]);
               chk("stall_way", k, cw,    prev_way[k]);
               chk("stall_wb",  k, wb[k], prev_wb[k]);
               chk("stall_valid", k, valid[k], 1);
            end
            if (sq[k].size() == 0) begin
               chk("no_req_expected", k, valid[k], 0);
            end else if (valid[k] && ready) begin
               e = sq[k].pop_front();
               chk("hs_idx", k, ci,    e.idx);
               chk("hs_way", k, cw,    e.way);
               chk("hs_wb",  k, wb[k], e.wb);
               if (e.wb == 0) init_cnt[k]++;
               if (e.last && e.wb == 1) pend_ack[k] = 1;
            end
            prev_stall[k] = valid[k] && !ready;
            prev_idx[k]   = ci;
            prev_way[k]   = cw;
            prev_wb[k]    = wb[k];
         end
      end
   end

   initial begin
      rst_n     = 1'b1;
      ready     = 1'b0;
      flush_req = 2'b00;
      #2 rst_n  = 1'b0;
      step(); step(); step();

      // Init sweep with ready held high.
      ready_mode = 0;
      rst_n = 1'b1;
      push_sweep(0, 0);
      push_sweep(1, 0);
      wait_init();
      for (int c = 0; c < 5; c++) step();

      // Flush sweep with random ready (ready high in IDLE must not count).
      ready_mode = 2;
      for (int c = 0; c < 4; c++) step();
      flush_req = 2'b11;
      push_sweep(0, 1);
      push_sweep(1, 1);
      wait_acks();
      chk("done_after_flush", 0, done[0], 1);
      chk("done_after_flush", 1, done[1], 1);
      for (int c = 0; c < 4; c++) step();

      // Re-init with ready toggling every cycle.
      rst_n = 1'b0;
      step(); step();
      ready_mode = 1;
      ready = 1'b0;
      rst_n = 1'b1;
      push_sweep(0, 0);
      push_sweep(1, 0);
      wait_init();

      // Flush requested from reset release: init first, then flush.
      rst_n = 1'b0;
      flush_req = 2'b11;
      step(); step();
      ready_mode = 2;
      rst_n = 1'b1;
      push_sweep(0, 0);
      push_sweep(1, 0);
      push_sweep(0, 1);
      push_sweep(1, 1);
      wait_acks();
      for (int c = 0; c < 4; c++) step();

      // Reset at the fifth flush handshake of dut0: no ack may follow.
      ready_mode = 0;
      flush_req = 2'b11;
      push_sweep(0, 1);
      push_sweep(1, 1);
      for (int c = 0; c < 100 && sq[0].size() > 2 * NSETS - 5; c++) step();
      chk("abort_point", 0, sq[0].size(), 2 * NSETS - 5);
      rst_n = 1'b0;
      flush_req = 2'b00;
      #1;
      chk("abort_valid", 0, valid[0], 1);
      chk("abort_idx",   0, idx0, 0);
      chk("abort_way",   0, way0, 0);
      chk("abort_done",  0, done[0], 0);
      step(); step();
      ready_mode = 2;
      rst_n = 1'b1;
      push_sweep(0, 0);
      push_sweep(1, 0);
      wait_init();
      for (int c = 0; c < 10; c++) step();

      chk("queue_drained", 0, sq[0].size(), 0);
      chk("queue_drained", 1, sq[1].size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
